// File: rtl/spi_adc_burst_mc.sv
// Multi-channel SPI ADC burst capture: one shared sclk/sync pair, a MISO line per channel,
// one-shot or continuous ring capture into a shared RAM with registered random-access readback.
module spi_adc_burst_mc #(
  parameter int FPGAClkSpeed        = 40000000,
  parameter int ADCSPIClkSpeed      = 2500000,
  parameter int NumChannels         = 2,
  parameter int FrameBits           = 16,
  parameter int SampleWidth         = 12,
  parameter int MaxADCBurstReadings = 13,
  localparam int N   = MaxADCBurstReadings,
  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [N:0]             burst_len_i,
  output logic                   adc_sclk_o,
  output logic                   adc_sync_no,
  input  logic [NumChannels-1:0] adc_miso_i,
  input  logic [N-1:0]           rd_addr_i,
  input  logic [ChW-1:0]         rd_ch_i,
  output logic [SampleWidth-1:0] rd_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [N:0]             sample_count_o,
  output logic                   wrapped_o
);
  localparam int H  = FPGAClkSpeed / (2 * ADCSPIClkSpeed);
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int BW = (FrameBits > 1) ? $clog2(FrameBits) : 1;
  localparam logic [HW-1:0] HLast = HW'(H - 1);
  localparam logic [BW-1:0] BLast = BW'(FrameBits - 1);
  localparam logic [N:0]    Full  = {1'b1, {N{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SHIFT, S_STORE, S_GAP, S_DONE} state_t;
  typedef logic [NumChannels-1:0][SampleWidth-1:0] word_t;

  state_t         state_q;
  logic [HW-1:0]  hcnt_q;
  logic [BW-1:0]  bcnt_q;
  logic           sclk_q, sync_n_q, busy_q, done_q, mode_q, wrapped_q, stop_pend_q;
  logic [N:0]     len_q, count_q;
  logic [N-1:0]   wptr_q;
  word_t          shreg_q;
  word_t          mem [2**N];
  word_t          rd_word_q;
  logic [ChW-1:0] rd_ch_q;

  logic [N-1:0] wptr_d;
  logic [N:0]   count_d;
  logic         half_end_d, stop_d, finish_d;

  always_comb begin
    wptr_d     = wptr_q + 1'b1;
    count_d    = (count_q == Full) ? count_q : count_q + 1'b1;
    half_end_d = (hcnt_q == HLast);
    stop_d     = stop_pend_q || (mode_q && stop_i);
    finish_d   = mode_q ? stop_d : (count_q == len_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      sclk_q      <= 1'b1;
      sync_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      wrapped_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && mode_q && stop_i) stop_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start_i && (mode_i || burst_len_i != '0)) begin
            mode_q    <= mode_i;
            len_q     <= burst_len_i;
            count_q   <= '0;
            wptr_q    <= '0;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b1;
            sync_n_q  <= 1'b0;
            hcnt_q    <= '0;
            state_q   <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (half_end_d) begin
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            sclk_q  <= 1'b0;
            state_q <= S_SHIFT;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (!half_end_d) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            hcnt_q <= '0;
            if (!sclk_q) begin
              // MISO is captured on the clock that raises sclk; older bits fall off the top
              sclk_q <= 1'b1;
              for (int c = 0; c < NumChannels; c++)
                shreg_q[c] <= SampleWidth'({shreg_q[c], adc_miso_i[c]});
            end else if (bcnt_q == BLast) begin
              sync_n_q <= 1'b1;
              state_q  <= S_STORE;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
              sclk_q <= 1'b0;
            end
          end
        end
        S_STORE: begin
          wptr_q  <= wptr_d;
          count_q <= count_d;
          if (wptr_q == '1) wrapped_q <= 1'b1;
          hcnt_q  <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (!half_end_d) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            hcnt_q <= '0;
            if (finish_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              sync_n_q <= 1'b0;
              state_q  <= S_SYNC;
            end
          end
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          stop_pend_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write is suppressed under reset so an aborted STORE never lands in the buffer
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == S_STORE) mem[wptr_q] <= shreg_q;
  end

  // Read-before-write: same-address read in the STORE clock returns the old word
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_word_q <= '0;
      rd_ch_q   <= '0;
    end else begin
      rd_word_q <= mem[rd_addr_i];
      rd_ch_q   <= rd_ch_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < NumChannels; c++)
      if (rd_ch_q == ChW'(c)) rd_data_o = rd_word_q[c];
  end

  assign adc_sclk_o     = sclk_q;
  assign adc_sync_no    = sync_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign sample_count_o = count_q;
  assign wrapped_o      = wrapped_q;

endmodule

// File: tb/tb_spi_adc_burst_mc.sv
// Bench for spi_adc_burst_mc: behavioural ADC frame source plus a reference buffer
// filled from "entry k mod depth holds the low bits of reading k".
module tb_spi_adc_burst_mc;
  localparam int NC = 2, FB = 16, SW = 12, N = 4, DEPTH = 16;

  logic          clk = 1'b0, reset_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, mode_i = 1'b0;
  logic [N:0]    burst_len_i = '0;
  logic          adc_sclk_o, adc_sync_no;
  logic [NC-1:0] adc_miso_i = '0;
  logic [N-1:0]  rd_addr_i = '0;
  logic [0:0]    rd_ch_i = '0;
  logic [SW-1:0] rd_data_o;
  logic          busy_o, done_o, wrapped_o;
  logic [N:0]    sample_count_o;

  spi_adc_burst_mc #(.FPGAClkSpeed(8), .ADCSPIClkSpeed(2), .NumChannels(NC), .FrameBits(FB),
                     .SampleWidth(SW), .MaxADCBurstReadings(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .burst_len_i(burst_len_i), .adc_sclk_o(adc_sclk_o), .adc_sync_no(adc_sync_no),
    .adc_miso_i(adc_miso_i), .rd_addr_i(rd_addr_i), .rd_ch_i(rd_ch_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .sample_count_o(sample_count_o), .wrapped_o(wrapped_o));

  always #5 clk = ~clk;

  // ADC model: frame chosen by reading index, MSB first, new bit after every sclk fall
  logic [FB-1:0] frames [NC][64];
  logic [SW-1:0] ref_mem [DEPTH][NC];
  int nfr = 0, bitn = 0, base = 0;
  int total = 0, bad = 0;

  always @(posedge adc_sync_no or negedge adc_sclk_o) begin
    if (adc_sync_no === 1'b1) begin
      nfr++;
      bitn = 0;
    end else if (bitn < FB) begin
      for (int c = 0; c < NC; c++) adc_miso_i[c] = frames[c][(nfr - base) & 63][FB-1-bitn];
      bitn++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic m, input int len);
    start_i = 1'b1; mode_i = m; burst_len_i = (N+1)'(len);
    step();
    start_i = 1'b0;
  endtask

  task automatic rd_chk(input int a, input int c, input logic [SW-1:0] exp, input string tag);
    rd_addr_i = N'(a); rd_ch_i = 1'(c);
    step();
    chk(tag, 32'(rd_data_o), 32'(exp));
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (done_o !== 1'b1 && n < max) begin step(); n++; end
    chk(tag, 32'(done_o), 1);
  endtask

  task automatic fill_random(input int r);
    for (int k = 0; k < r; k++)
      for (int c = 0; c < NC; c++) frames[c][k] = 16'($urandom);
  endtask

  task automatic apply_capture(input int r);
    for (int k = 0; k < r; k++)
      for (int c = 0; c < NC; c++) ref_mem[k % DEPTH][c] = frames[c][k][SW-1:0];
  endtask

  initial begin
    int lowc, done_at, dcnt, n, sclk_low, busy_seen, found;
    logic prev;
    logic [SW-1:0] old_v;

    // reset values while reset is held
    repeat (3) step();
    chk("rst_sclk", 32'(adc_sclk_o), 1);
    chk("rst_sync_n", 32'(adc_sync_no), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_count", 32'(sample_count_o), 0);
    chk("rst_wrapped", 32'(wrapped_o), 0);
    chk("rst_rd_data", 32'(rd_data_o), 0);
    reset_i = 1'b0;
    step();

    // 1: single reading, fixed frames, timing
    frames[0][0] = 16'hA123; frames[1][0] = 16'h5FFF;
    base = nfr;
    pulse_start(1'b0, 1);
    chk("t1_busy", 32'(busy_o), 1);
    lowc = 0; done_at = 0; dcnt = 0;
    for (int c = 1; c <= 150; c++) begin
      if (adc_sync_no === 1'b0) lowc++;
      if (done_o === 1'b1) begin dcnt++; if (done_at == 0) done_at = c; end
      step();
    end
    chk("t1_sync_low", lowc, 66);
    chk("t1_done_at", done_at, 70);
    chk("t1_done_pulses", dcnt, 1);
    chk("t1_busy_end", 32'(busy_o), 0);
    chk("t1_count", 32'(sample_count_o), 1);
    chk("t1_wrapped", 32'(wrapped_o), 0);
    chk("t1_frames", nfr - base, 1);
    apply_capture(1);
    rd_chk(0, 0, 12'h123, "t1_e0_c0");
    rd_chk(0, 1, 12'hFFF, "t1_e0_c1");

    // 2: one-shot full buffer with random data; a start while busy is ignored
    fill_random(16);
    base = nfr;
    pulse_start(1'b0, 16);
    repeat (100) step();
    pulse_start(1'b1, 3);
    wait_done(16*69 + 50, "t2_done");
    step();
    chk("t2_busy", 32'(busy_o), 0);
    chk("t2_count", 32'(sample_count_o), 16);
    chk("t2_wrapped", 32'(wrapped_o), 1);
    chk("t2_frames", nfr - base, 16);
    apply_capture(16);
    for (int e = 0; e < DEPTH; e++)
      for (int c = 0; c < NC; c++) rd_chk(e, c, ref_mem[e][c], $sformatf("t2_e%0d_c%0d", e, c));

    // 3: continuous ring, stop during SHIFT of reading 20
    fill_random(24);
    base = nfr;
    pulse_start(1'b1, 0);
    n = 0;
    while (!((nfr - base) == 20 && adc_sclk_o === 1'b0) && n < 25*69) begin step(); n++; end
    chk("t3_reach_r20", nfr - base, 20);
    repeat (5) step();
    stop_i = 1'b1; step(); stop_i = 1'b0;
    wait_done(300, "t3_done");
    step();
    chk("t3_busy", 32'(busy_o), 0);
    chk("t3_count", 32'(sample_count_o), 16);
    chk("t3_wrapped", 32'(wrapped_o), 1);
    chk("t3_frames", nfr - base, 21);
    apply_capture(21);
    rd_chk(4, 0, frames[0][20][SW-1:0], "t3_e4_c0_r20");
    for (int e = 0; e < DEPTH; e++)
      rd_chk(e, 1, ref_mem[e][1], $sformatf("t3_e%0d_c1", e));

    // 4: stop in IDLE and a zero-length one-shot start are both ignored
    stop_i = 1'b1; step(); stop_i = 1'b0;
    pulse_start(1'b0, 0);
    sclk_low = 0; busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (adc_sclk_o === 1'b0) sclk_low++;
      if (busy_o === 1'b1) busy_seen++;
      step();
    end
    chk("t4_sclk_idle", sclk_low, 0);
    chk("t4_busy_idle", busy_seen, 0);
    chk("t4_count_kept", 32'(sample_count_o), 16);

    // 5: reset during SHIFT of reading 3
    fill_random(8);
    base = nfr;
    pulse_start(1'b0, 8);
    n = 0;
    while (!((nfr - base) == 3 && adc_sclk_o === 1'b0) && n < 5*69) begin step(); n++; end
    chk("t5_reach_r3", nfr - base, 3);
    repeat (3) step();
    reset_i = 1'b1;
    step();
    chk("t5_sclk", 32'(adc_sclk_o), 1);
    chk("t5_sync_n", 32'(adc_sync_no), 1);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_count", 32'(sample_count_o), 0);
    chk("t5_wrapped", 32'(wrapped_o), 0);
    chk("t5_rd_data", 32'(rd_data_o), 0);
    reset_i = 1'b0;
    step();
    apply_capture(3);
    for (int e = 0; e < 4; e++) rd_chk(e, 0, ref_mem[e][0], $sformatf("t5_e%0d_c0", e));

    // 6: read entry 5 in its STORE clock, then one clock later
    fill_random(8);
    base = nfr;
    pulse_start(1'b0, 8);
    prev = adc_sync_no; found = 0; n = 0;
    while (found == 0 && n < 8*69) begin
      if (adc_sync_no === 1'b1 && prev === 1'b0 && (nfr - base) == 6) found = 1;
      else begin prev = adc_sync_no; step(); n++; end
    end
    chk("t6_store_found", found, 1);
    old_v = ref_mem[5][0];
    rd_chk(5, 0, old_v, "t6_old");
    step();
    chk("t6_new", 32'(rd_data_o), 32'(frames[0][5][SW-1:0]));
    wait_done(300, "t6_done");
    step();
    chk("t6_count", 32'(sample_count_o), 8);
    chk("t6_wrapped", 32'(wrapped_o), 0);
    apply_capture(8);
    for (int e = 0; e < 8; e++) rd_chk(e, 1, ref_mem[e][1], $sformatf("t6_e%0d_c1", e));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_adc_burst_mc.md
Name: spi_adc_burst_mc

Overview:
Parametrised multi-channel SPI ADC burst-capture engine for the 6502 system. It drives one shared sclk/sync pair to NumChannels simultaneously sampling ADCs, each with its own MISO line. Readings go into an internal buffer of 2**MaxADCBurstReadings entries. It adds continuous ring-capture mode, a programmable burst length and random-access readback for the CPU-side peripheral wrapper.

Parameters:
FPGAClkSpeed, 40000000, system clock frequency in Hz
ADCSPIClkSpeed, 2500000, SPI clock frequency in Hz; H = FPGAClkSpeed/(2*ADCSPIClkSpeed) clocks per half period, must be an integer >= 1
NumChannels, 2, number of ADC MISO lines (1..8)
FrameBits, 16, sclk cycles per conversion frame
SampleWidth, 12, stored bits per reading (<= FrameBits)
MaxADCBurstReadings, 13, log2 of buffer depth (N)

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  one-clock start pulse
stop_i  in  1  one-clock stop request (continuous mode)
mode_i  in  1  0 = one-shot burst, 1 = continuous ring; sampled at start
burst_len_i  in  N+1  readings per one-shot burst (1..2**N); sampled at start
adc_sclk_o  out  1  SPI clock, idles high
adc_sync_no  out  1  conversion frame select, active low
adc_miso_i  in  NumChannels  per-channel serial data
rd_addr_i  in  N  readback entry index
rd_ch_i  in  max(1,$clog2(NumChannels))  readback channel
rd_data_o  out  SampleWidth  readback data, registered
busy_o  out  1  capture in progress
done_o  out  1  one-clock pulse at capture end
sample_count_o  out  N+1  readings stored in current/last capture
wrapped_o  out  1  sticky: ring write pointer wrapped

Behaviour:
- Reset (synchronous, any state): state IDLE; sclk=1, sync_n=1, busy=0, done=0, sample_count=0, wrapped=0, write pointer=0, rd_data_o=0. Buffer contents are not cleared. Reset mid-frame aborts on the next edge; no partial frame is written.
- States: IDLE -> SYNC -> SHIFT -> STORE -> GAP -> (SYNC | DONE) -> IDLE.
- IDLE: start_i=1 with burst_len_i != 0 or mode_i=1 latches mode and length, clears sample_count, wrapped and write pointer, sets busy, and goes to SYNC. start_i with mode_i=0 and burst_len_i=0 is ignored. start_i outside IDLE is ignored.
- SYNC: sync_n=0, sclk=1 for H clocks.
- SHIFT: FrameBits bit periods. Each period is sclk=0 for H clocks, then sclk=1 for H clocks. On the clock where sclk goes 0->1, every channel's MISO bit is shifted in, MSB first.
- STORE: 1 clock. sync_n=1, sclk=1. For each channel, the low SampleWidth bits of its frame are written at the write pointer. The write pointer increments modulo 2**N. sample_count increments and saturates at 2**N. If the pointer wraps from 2**N-1 to 0, wrapped_o is set.
- GAP: sync_n=1 for H clocks. Exit conditions:
  - One-shot: if sample_count == latched length, go to DONE.
  - Continuous: if a stop is pending, go to DONE.
  - Otherwise go to SYNC.
- Cycle cost: H + 2*H*FrameBits + 1 + H clocks per reading (273 at defaults).
- stop_i: latched as pending whenever busy, in any state; the current frame always completes and is stored. Ignored in one-shot mode and in IDLE. Cleared on entry to IDLE.
- DONE: 1 clock. done_o=1, busy drops to 0 on the following clock (IDLE).
- Readback: rd_data_o is registered with 1-clock latency from rd_addr_i/rd_ch_i. Reads are allowed while busy. A read of the same address in the STORE clock returns the old data. rd_ch_i >= NumChannels returns 0.
- Buffer is a single RAM with words NumChannels*SampleWidth wide, inferred as block RAM.

Test Plan:
1. FPGAClkSpeed=8, ADCSPIClkSpeed=2 (H=2), NumChannels=2, FrameBits=16, SampleWidth=12, N=4. Model drives frames 0xA123 on ch0 and 0x5FFF on ch1; start, mode=0, len=1 -> sync_n low for 2+64 clocks; entry0 ch0 reads 0x123, ch1 reads 0xFFF; done_o pulses 70 clocks after start is accepted, sample_count=1.
2. One-shot, len=16, model data = reading index -> entries 0..15 hold 0..15, wrapped_o=1, sample_count=16, exactly 16 sync_n low pulses.
3. Continuous mode, stop_i asserted mid-SHIFT of reading 20 -> reading 20 completes; 21 readings total; sample_count=16; wrapped=1; entry 4 holds reading 20.
4. start with mode=0, len=0 -> busy stays 0, no sclk activity. start_i pulsed while busy -> no effect on length or count.
5. reset_i asserted mid-SHIFT of reading 3 -> next clock sclk=1, sync_n=1, busy=0, count=0; entries 0..2 retain their data.
6. Read entry 5 during its STORE clock -> rd_data_o returns old value; a read one clock later returns the new value.
